// File: rtl/reg_sel_decoder_if.sv
// Request/select bundle for reg_sel_decoder.
// The master drives the request and clear; the slave returns the select lines and status.
interface reg_sel_decoder_if #(
  parameter int ADDR_W = 5
);
  localparam int OUT_W = 2 ** ADDR_W;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [1:0]        mode;
  logic              clear;
  logic [OUT_W-1:0]  sel;
  logic              sel_valid;
  logic              busy;
  logic              sweep_done;

  modport master (
    output in_valid, addr, en, mode, clear,
    input  in_ready, sel, sel_valid, busy, sweep_done
  );

  modport slave (
    input  in_valid, addr, en, mode, clear,
    output in_ready, sel, sel_valid, busy, sweep_done
  );
endinterface

// File: rtl/reg_sel_decoder.sv
// Registered ADDR_W-to-2^ADDR_W one-hot decoder with pulse, hold and sweep modes.
// Drives register-file write enables; bit 0 can be hard-masked for a constant R0.
module reg_sel_decoder #(
  parameter int ADDR_W    = 5,
  parameter bit ZERO_MASK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  reg_sel_decoder_if.slave bus
);
  localparam int OUT_W = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_SWEEP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_PULSE = 2'd0,
    M_HOLD  = 2'd1,
    M_SWEEP = 2'd2,
    M_ALT   = 2'd3
  } mode_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [OUT_W-1:0]  r_sel;
  logic              r_sel_valid;
  logic              r_busy;
  logic              r_sweep_done;

  logic              w_accept;
  logic [OUT_W-1:0]  w_req_sel;
  logic [ADDR_W-1:0] w_next_idx;
  logic [OUT_W-1:0]  w_step_sel;
  logic              w_last_step;
  mode_t             w_mode;

  function automatic logic [OUT_W-1:0] f_decode(input logic [ADDR_W-1:0] a, input logic e);
    logic [OUT_W-1:0] v;
    v = e ? (OUT_W'(1) << a) : '0;
    if (ZERO_MASK) v[0] = 1'b0;
    return v;
  endfunction

  assign bus.in_ready  = !r_busy && !bus.clear;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_mode        = mode_t'(bus.mode);
  assign w_next_idx    = r_idx + ADDR_W'(1);
  assign w_last_step   = &r_idx;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_req_sel  = '0;
    w_step_sel = '0;
    w_req_sel  = f_decode(bus.addr, bus.en);
    w_step_sel = f_decode(w_next_idx, 1'b1);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_sel        <= '0;
      r_sel_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        S_SWEEP: begin
          if (bus.clear || w_last_step) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            // r_idx always mirrors the step currently shown on sel.
            r_idx        <= w_next_idx;
            r_sel        <= w_step_sel;
            r_sel_valid  <= 1'b1;
            r_sweep_done <= &w_next_idx;
          end
        end

        default: begin
          if (w_accept) begin
            r_sel_valid <= 1'b1;
            case (w_mode)
              M_HOLD: begin
                r_state <= S_HOLD;
                r_sel   <= w_req_sel;
                r_busy  <= 1'b0;
              end
              M_SWEEP: begin
                if (bus.en) begin
                  r_state      <= S_SWEEP;
                  r_idx        <= bus.addr;
                  r_sel        <= w_req_sel;
                  r_busy       <= 1'b1;
                  r_sweep_done <= &bus.addr;
                end else begin
                  r_state <= S_IDLE;
                  r_sel   <= '0;
                  r_busy  <= 1'b0;
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_sel   <= w_req_sel;
                r_busy  <= 1'b0;
              end
            endcase
          end else if (r_state == S_HOLD && !bus.clear) begin
            r_state <= S_HOLD;
          end else begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.sel        = r_sel;
  assign bus.sel_valid  = r_sel_valid;
  assign bus.busy       = r_busy;
  assign bus.sweep_done = r_sweep_done;
endmodule

// File: tb/tb_reg_sel_decoder.sv
// Directed-vector bench for reg_sel_decoder: table-driven pulse/hold vectors plus
// hand-written sweep, abort, reset, contention and random one-hot sequences.
module tb_reg_sel_decoder;
  logic clk;
  logic rst;

  int n_pass;
  int n_total;

  reg_sel_decoder_if #(.ADDR_W(5)) bus  ();
  reg_sel_decoder_if #(.ADDR_W(5)) bus0 ();

  reg_sel_decoder #(.ADDR_W(5), .ZERO_MASK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  reg_sel_decoder #(.ADDR_W(5), .ZERO_MASK(1'b0)) dut_nomask (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        v;
    logic [4:0]  addr;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] exp_sel;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic e, input logic [1:0] m);
    bus.in_valid = v;
    bus.addr     = a;
    bus.en       = e;
    bus.mode     = m;
  endtask

  task automatic check_outs(input string name, input logic [31:0] s, input logic sv,
                            input logic b, input logic sd);
    check({name, ".sel"},        bus.sel,        s);
    check({name, ".sel_valid"},  32'(bus.sel_valid),  32'(sv));
    check({name, ".busy"},       32'(bus.busy),       32'(b));
    check({name, ".sweep_done"}, 32'(bus.sweep_done), 32'(sd));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 2'd0);
    bus.clear = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.addr     = 5'd0;
    bus0.en       = 1'b0;
    bus0.mode     = 2'd0;
    bus0.clear    = 1'b0;

    vecs[0]  = '{1'b1, 5'd7,  1'b1, 2'd0, 32'h0000_0080, 1'b1};
    vecs[1]  = '{1'b0, 5'd7,  1'b1, 2'd0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  1'b1, 2'd0, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b1, 5'd5,  1'b0, 2'd0, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 5'd9,  1'b1, 2'd3, 32'h0000_0200, 1'b1};
    vecs[5]  = '{1'b1, 5'd3,  1'b1, 2'd1, 32'h0000_0008, 1'b1};
    vecs[6]  = '{1'b0, 5'd3,  1'b1, 2'd1, 32'h0000_0008, 1'b1};
    vecs[7]  = '{1'b0, 5'd12, 1'b1, 2'd0, 32'h0000_0008, 1'b1};
    vecs[8]  = '{1'b1, 5'd31, 1'b1, 2'd1, 32'h8000_0000, 1'b1};
    vecs[9]  = '{1'b1, 5'd4,  1'b1, 2'd0, 32'h0000_0010, 1'b1};
    vecs[10] = '{1'b0, 5'd4,  1'b1, 2'd0, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 5'd2,  1'b0, 2'd2, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 5'd2,  1'b0, 2'd2, 32'h0000_0000, 1'b0};

    // Reset state, including in_ready tracking clear while reset is held.
    #1;
    check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    bus.clear = 1'b1;
    #1;
    check("reset.in_ready_clear", 32'(bus.in_ready), 32'd0);
    bus.clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table-driven pulse / hold / replace vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].addr, vecs[i].en, vecs[i].mode);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_valid, 1'b0, 1'b0);
      check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
    end

    // Hold for 10 idle cycles with addr wiggling, then replace, then clear.
    drive(1'b1, 5'd3, 1'b1, 2'd1);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 5'(k + 11), 1'b1, 2'd0);
      tick();
      check($sformatf("hold%0d.sel", k), bus.sel, 32'h0000_0008);
      check($sformatf("hold%0d.sel_valid", k), 32'(bus.sel_valid), 32'd1);
    end
    drive(1'b1, 5'd31, 1'b1, 2'd1);
    tick();
    check("hold_replace.sel", bus.sel, 32'h8000_0000);
    drive(1'b0, 5'd0, 1'b0, 2'd0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_outs("hold_clear", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("hold_clear_idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Sweep from 28: a conflicting request is held high throughout and must be ignored.
    drive(1'b1, 5'd28, 1'b1, 2'd2);
    tick();
    drive(1'b1, 5'd1, 1'b1, 2'd1);
    for (int k = 0; k < 4; k++) begin
      check_outs($sformatf("sweep28_%0d", k), 32'h1 << (28 + k), 1'b1, 1'b1, k == 3);
      check($sformatf("sweep28_%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
      if (k == 3) drive(1'b0, 5'd0, 1'b0, 2'd0);
      tick();
    end
    check_outs("sweep28_end", 32'h0, 1'b0, 1'b0, 1'b0);
    check("sweep28_end.in_ready", 32'(bus.in_ready), 32'd1);

    // Sweep from 31 lasts exactly one step.
    drive(1'b1, 5'd31, 1'b1, 2'd2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0);
    check_outs("sweep31", 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    tick();
    check_outs("sweep31_end", 32'h0, 1'b0, 1'b0, 1'b0);

    // Sweep from 0 aborted by clear on the 3rd step; masked bit 0 still takes a cycle.
    drive(1'b1, 5'd0, 1'b1, 2'd2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0);
    check_outs("abort_step1", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("abort_step2", 32'h2, 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("abort_step3", 32'h4, 1'b1, 1'b1, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_outs("abort_end", 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      tick();
      check($sformatf("abort_quiet%0d", k), 32'(bus.sweep_done), 32'd0);
    end

    // Asynchronous reset between edges, mid-sweep.
    drive(1'b1, 5'd10, 1'b1, 2'd2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0);
    tick();
    check("rst_sweep_pre.sel", bus.sel, 32'h0000_0800);
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_sweep", 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_sweep.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_outs("rst_sweep_after", 32'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-hold.
    drive(1'b1, 5'd20, 1'b1, 2'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0);
    check("rst_hold_pre.sel", bus.sel, 32'h0010_0000);
    #3;
    rst = 1'b1;
    #1;
    check_outs("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_outs("rst_hold_after", 32'h0, 1'b0, 1'b0, 1'b0);

    // Clear and in_valid together: not accepted.
    drive(1'b1, 5'd6, 1'b1, 2'd1);
    bus.clear = 1'b1;
    #1;
    check("contend.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check_outs("contend", 32'h0, 1'b0, 1'b0, 1'b0);
    bus.clear = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0);
    tick();
    check_outs("contend_after", 32'h0, 1'b0, 1'b0, 1'b0);

    // ZERO_MASK=0 instance: bit 0 is a real select.
    bus0.in_valid = 1'b1;
    bus0.addr     = 5'd0;
    bus0.en       = 1'b1;
    bus0.mode     = 2'd0;
    tick();
    bus0.in_valid = 1'b0;
    check("nomask.sel", bus0.sel, 32'h0000_0001);
    check("nomask.sel_valid", 32'(bus0.sel_valid), 32'd1);
    tick();
    check("nomask_end.sel", bus0.sel, 32'h0);

    // Random stream: one-hot invariant and no stray select without sel_valid.
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)), 2'($urandom));
      bus.clear = ($urandom_range(0, 9) == 0);
      tick();
      check($sformatf("rand%0d.onehot", k), 32'($countones(bus.sel) <= 1), 32'd1);
      check($sformatf("rand%0d.sel_implies_valid", k),
            32'((bus.sel == '0) || bus.sel_valid), 32'd1);
    end
    bus.clear = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_sel_decoder.md
# reg_sel_decoder

Parametrised, registered ADDR_W-to-2^ADDR_W one-hot decoder with a valid/ready request port and three output modes: pulse, hold and sweep. It drives the register-file write-enable lines in the CPU. It also serves as a generic select generator for the datapath and test logic, where the existing fixed-width combinational decoders have no timing control.

## Interface
Parameters:
- ADDR_W, default 5: address width. OUT_W = 2**ADDR_W is derived and not overridable.
- ZERO_MASK, default 1: when 1, output bit 0 is never asserted (hard-wired R0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  combinational: !busy && !clear.
- addr  in  ADDR_W  address to decode; sweep start index in mode 10.
- en  in  1  decode enable, sampled at accept.
- mode  in  2  00 pulse, 01 hold, 10 sweep, 11 treated as 00.
- clear  in  1  synchronous clear/abort.
- sel  out  OUT_W  registered one-hot select.
- sel_valid  out  1  registered; sel carries a decoded value this cycle.
- busy  out  1  registered; high while in SWEEP.
- sweep_done  out  1  registered; one-cycle pulse on the last sweep step.

## Operation
- A request is accepted when in_valid && in_ready.
- Decoded value: onehot = en ? (1 << addr) : 0. If ZERO_MASK=1, bit 0 is forced to 0 after decode.
- States: IDLE, HOLD, SWEEP. Reset enters IDLE.
- IDLE:
  - Accept in mode 00/11: sel=onehot and sel_valid=1 for exactly one cycle, then sel=0 and sel_valid=0. State stays IDLE.
  - Accept in mode 01: sel=onehot, sel_valid=1, go to HOLD.
  - Accept in mode 10 with en=1: idx=addr, go to SWEEP.
  - Accept in mode 10 with en=0: one-cycle sel_valid=1 with sel=0, no sweep, and no sweep_done.
- HOLD:
  - sel and sel_valid hold until a new accept or clear.
  - A new accept replaces sel per that request's mode. Mode 00 from HOLD yields a one-cycle pulse, then IDLE with sel=0.
  - clear=1 gives sel=0, sel_valid=0 and IDLE next cycle.
- SWEEP:
  - Each cycle: sel=1<<idx (masked), sel_valid=1, busy=1, then idx increments.
  - When idx==OUT_W-1, sweep_done=1 in the same cycle as that sel. The next cycle is IDLE with sel=0, sel_valid=0, busy=0.
  - No wrap-around: a sweep started at addr=OUT_W-1 lasts one step.
  - clear=1 aborts the sweep: next cycle is IDLE with all outputs 0, and sweep_done is never asserted.
  - Under ZERO_MASK, the idx=0 step still consumes a cycle with sel_valid=1 and sel=0.
- clear and in_valid in the same cycle: in_ready=0, so the request is not accepted and the clear is applied.
- clear in IDLE has no effect beyond forcing in_ready low.
- Invariant: popcount(sel) <= 1 at all times.

## Timing
- rst asserted: sel=0, sel_valid=0, busy=0, sweep_done=0, state IDLE, idx=0. This takes effect immediately, without waiting for a clock edge. in_ready = !clear during reset.
- Reset mid-sweep or mid-hold drops all outputs asynchronously. The first cycle after deassertion is IDLE.
- Latency: sel/sel_valid update on the edge where the request is accepted, i.e. they are visible 1 cycle after the accept cycle.
- Back-to-back pulse requests produce sel updated every cycle with no gap cycle.
- Sweep from start s occupies OUT_W-s cycles, with busy high for exactly those cycles.
- in_ready goes high in the cycle after the sweep_done cycle.
- Throughput: one accept per cycle outside SWEEP.
- Sampling: addr, en and mode are sampled only at accept. Changes while busy or in HOLD are ignored.

## Test plan
- Pulse, ADDR_W=5, ZERO_MASK=1: addr=7, mode 00, en=1 -> next cycle sel=32'h0000_0080 and sel_valid=1; the following cycle sel=0 and sel_valid=0.
- Hold then replace: addr=3 in mode 01 -> sel=32'h8 held for 10 idle cycles. Then addr=31 in mode 01 -> sel=32'h8000_0000. Then clear -> sel=0 and IDLE.
- Zero mask and enable: addr=0 with en=1 -> sel=0 and sel_valid=1. addr=5 with en=0 -> sel=0 and sel_valid=1. With ZERO_MASK=0, addr=0 -> sel=32'h1.
- Sweep: addr=28 in mode 10 -> sel steps through bits 28, 29, 30, 31 on 4 consecutive cycles. busy=1 and in_ready=0 throughout; sweep_done=1 with bit 31; then IDLE.
- Abort and reset: start a sweep at addr=0 and assert clear on the 3rd step -> outputs 0 next cycle with no sweep_done. Start a new sweep and assert rst between clock edges -> outputs 0 immediately.
- Contention: clear=1 with in_valid=1 in mode 01 -> request not accepted and sel stays 0. Across a random request stream, popcount(sel) <= 1 every cycle.
